// File: rtl/playlist_sequencer.sv
// playlist_sequencer
//   Walks the song player through a playlist. Turns single-cycle user pulses
//   (play/pause, next, prev) and the player's song_done pulse into the player's
//   play / reset_player / song inputs, inserting a silent gap between songs
//   when advancing automatically.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   play_pause    pulse: start, pause or resume
//   next_btn      pulse: skip to the next song
//   prev_btn      pulse: back to the previous song
//   repeat_mode   level: 1 = wrap after the last song, 0 = stop after it
//   song_done     pulse from the player: current song finished
//   play          registered, 1 while PLAYING
//   reset_player  registered, 1 during the single LOAD cycle
//   song          registered, current song index
//   status        current state code (IDLE=0 LOAD=1 PLAYING=2 PAUSED=3 GAP=4)
//
// Handshake: there is no valid/ready flow control here. Every input pulse is
// sampled on exactly one rising edge and either acts or is dropped; nothing is
// queued or back-pressured.
module playlist_sequencer #(
   parameter int NUM_SONGS  = 16,
   parameter int SONG_W     = 4,
   parameter int GAP_CYCLES = 4800
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_pause,
   input  logic              next_btn,
   input  logic              prev_btn,
   input  logic              repeat_mode,
   input  logic              song_done,
   output logic              play,
   output logic              reset_player,
   output logic [SONG_W-1:0] song,
   output logic [2:0]        status
);

   localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_PLAYING = 3'd2,
      S_PAUSED  = 3'd3,
      S_GAP     = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [SONG_W-1:0] song_n, song_inc, song_dec;
   logic [CNT_W-1:0]  gap_cnt, gap_n;
   logic              play_n, reset_player_n;
   logic              sel_next, sel_prev, sel_done, sel_pp;

   // Only the highest-ranked pulse survives; lower ones are dropped even if the
   // winner turns out to be meaningless in the current state.
   assign sel_next = next_btn;
   assign sel_prev = !next_btn && prev_btn;
   assign sel_done = !next_btn && !prev_btn && song_done;
   assign sel_pp   = !next_btn && !prev_btn && !song_done && play_pause;

   // Wrap at NUM_SONGS, which need not be a power of two.
   assign song_inc = (song == LAST_SONG) ? '0 : song + 1'b1;
   assign song_dec = (song == '0) ? LAST_SONG : song - 1'b1;

   assign status = state;

   always_comb begin
      state_n = state;
      song_n  = song;
      gap_n   = gap_cnt;
      case (state)
         S_IDLE: begin
            if (sel_next)      song_n  = song_inc;
            else if (sel_prev) song_n  = song_dec;
            else if (sel_pp)   state_n = S_LOAD;
         end
         S_LOAD: state_n = S_PLAYING;
         S_PLAYING: begin
            if (sel_next || sel_prev) begin
               song_n  = sel_next ? song_inc : song_dec;
               state_n = S_LOAD;
            end else if (sel_done) begin
               state_n = S_GAP;
               gap_n   = GAP_LOAD;
            end else if (sel_pp) begin
               state_n = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (sel_next || sel_prev) begin
               song_n  = sel_next ? song_inc : song_dec;
               state_n = S_LOAD;
            end else if (sel_pp) begin
               // Resume without reset_player so the player continues mid-song.
               state_n = S_PLAYING;
            end
         end
         S_GAP: begin
            if (sel_next || sel_prev) begin
               song_n  = sel_next ? song_inc : song_dec;
               state_n = S_LOAD;
            end else if (sel_pp) begin
               state_n = S_IDLE;
            end else if (gap_cnt == '0) begin
               // repeat_mode only matters on this expiry cycle.
               if (song == LAST_SONG && !repeat_mode) begin
                  song_n  = '0;
                  state_n = S_IDLE;
               end else begin
                  song_n  = song_inc;
                  state_n = S_LOAD;
               end
            end else begin
               gap_n = gap_cnt - CNT_W'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase
      play_n         = (state_n == S_PLAYING);
      reset_player_n = (state_n == S_LOAD);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         song         <= '0;
         gap_cnt      <= '0;
         play         <= 1'b0;
         reset_player <= 1'b0;
      end else begin
         state        <= state_n;
         song         <= song_n;
         gap_cnt      <= gap_n;
         play         <= play_n;
         reset_player <= reset_player_n;
      end
   end

endmodule

// File: tb/tb_playlist_sequencer.sv
// Bench for playlist_sequencer: two instances (16 songs / gap 4 and
// 10 songs / gap 3) share one stimulus stream and are compared against a
// behavioural playlist model.
module tb_playlist_sequencer;

   logic       clk, rst;
   logic       play_pause, next_btn, prev_btn, repeat_mode, song_done;
   logic       play_a, rp_a, play_b, rp_b;
   logic [3:0] song_a, song_b;
   logic [2:0] status_a, status_b;

   int tests_run = 0;
   int tests_failed = 0;

   playlist_sequencer #(.NUM_SONGS(16), .SONG_W(4), .GAP_CYCLES(4)) dut_a (
      .clk(clk), .reset(rst), .play_pause(play_pause), .next_btn(next_btn),
      .prev_btn(prev_btn), .repeat_mode(repeat_mode), .song_done(song_done),
      .play(play_a), .reset_player(rp_a), .song(song_a), .status(status_a));

   playlist_sequencer #(.NUM_SONGS(10), .SONG_W(4), .GAP_CYCLES(3)) dut_b (
      .clk(clk), .reset(rst), .play_pause(play_pause), .next_btn(next_btn),
      .prev_btn(prev_btn), .repeat_mode(repeat_mode), .song_done(song_done),
      .play(play_b), .reset_player(rp_b), .song(song_b), .status(status_b));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_PAUSE = 3, M_GAP = 4;
   typedef struct {
      int state;
      int song;
      int gap;
   } model_t;
   model_t ma, mb;

   function automatic model_t step(model_t m, int n, int gap_cycles,
                                   bit pp, bit nx, bit pv, bit sd, bit rep);
      model_t r = m;
      int top;  // 1=next 2=prev 3=done 4=play_pause 0=none
      top = nx ? 1 : pv ? 2 : sd ? 3 : pp ? 4 : 0;
      if (m.state == M_LOAD) begin
         r.state = M_PLAY;
      end else if (m.state != M_IDLE && (top == 1 || top == 2)) begin
         r.song  = (top == 1) ? (m.song + 1) % n : (m.song + n - 1) % n;
         r.state = M_LOAD;
      end else if (m.state == M_IDLE) begin
         if (top == 1)      r.song  = (m.song + 1) % n;
         else if (top == 2) r.song  = (m.song + n - 1) % n;
         else if (top == 4) r.state = M_LOAD;
      end else if (m.state == M_PLAY) begin
         if (top == 3) begin
            r.state = M_GAP;
            r.gap   = gap_cycles - 1;
         end else if (top == 4) r.state = M_PAUSE;
      end else if (m.state == M_PAUSE) begin
         if (top == 4) r.state = M_PLAY;
      end else begin
         if (top == 4) r.state = M_IDLE;
         else if (m.gap == 0) begin
            if (m.song == n - 1 && !rep) begin
               r.song  = 0;
               r.state = M_IDLE;
            end else begin
               r.song  = (m.song + 1) % n;
               r.state = M_LOAD;
            end
         end else r.gap = m.gap - 1;
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma = '{M_IDLE, 0, 0};
         mb = '{M_IDLE, 0, 0};
      end else begin
         ma = step(ma, 16, 4, play_pause, next_btn, prev_btn, song_done, repeat_mode);
         mb = step(mb, 10, 3, play_pause, next_btn, prev_btn, song_done, repeat_mode);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit pp, input bit nx, input bit pv, input bit sd);
      play_pause = pp; next_btn = nx; prev_btn = pv; song_done = sd;
      tick();
      play_pause = 0; next_btn = 0; prev_btn = 0; song_done = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      play_pause = 0; next_btn = 0; prev_btn = 0; song_done = 0;
      tick();
      tick();
      rst = 0;
   endtask

   // play from IDLE on current song, leave in PLAYING
   task automatic start_play();
      pulse(1, 0, 0, 0);
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [8:0] obs;
      do_reset();
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== 9'h000) begin
         tests_failed++;
         $display("FAIL reset_state got=%h exp=%h", obs, 9'h000);
      end
      pulse(1, 0, 0, 0);
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== {3'd1, 4'd0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL start_load got=%h exp=%h", obs, {3'd1, 4'd0, 1'b0, 1'b1});
      end
      tick();
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== {3'd2, 4'd0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL start_playing got=%h exp=%h", obs, {3'd2, 4'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_gap_advance();
      logic [8:0] obs;
      do_reset();
      repeat (3) pulse(0, 1, 0, 0);
      start_play();
      pulse(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         obs = {status_a, song_a, play_a, rp_a};
         tests_run++;
         if (obs !== {3'd4, 4'd3, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL gap_cycle%0d got=%h exp=%h", i, obs, {3'd4, 4'd3, 1'b0, 1'b0});
         end
         tick();
      end
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== {3'd1, 4'd4, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL gap_to_load got=%h exp=%h", obs, {3'd1, 4'd4, 1'b0, 1'b1});
      end
      tick();
      tests_run++;
      if (play_a !== 1'b1) begin
         tests_failed++;
         $display("FAIL gap_then_play got=%b exp=1", play_a);
      end
   endtask

   task automatic test_last_song();
      logic [8:0] obs;
      for (int rep = 0; rep < 2; rep++) begin
         repeat_mode = rep[0];
         do_reset();
         pulse(0, 0, 1, 0);
         start_play();
         pulse(0, 0, 0, 1);
         for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (rp_a !== 1'b0) begin
               tests_failed++;
               $display("FAIL last_gap_rp rep=%0d got=%b exp=0", rep, rp_a);
            end
         end
         tick();
         obs = {status_a, song_a, play_a, rp_a};
         if (rep == 0) begin
            tests_run++;
            if (obs !== {3'd0, 4'd0, 1'b0, 1'b0}) begin
               tests_failed++;
               $display("FAIL last_stop got=%h exp=%h", obs, {3'd0, 4'd0, 1'b0, 1'b0});
            end
         end else begin
            tests_run++;
            if (obs !== {3'd1, 4'd0, 1'b0, 1'b1}) begin
               tests_failed++;
               $display("FAIL last_wrap got=%h exp=%h", obs, {3'd1, 4'd0, 1'b0, 1'b1});
            end
         end
      end
      repeat_mode = 0;
   endtask

   task automatic test_wrap();
      do_reset();
      pulse(0, 0, 1, 0);
      tests_run++;
      if ({status_a, song_a, status_b, song_b} !== {3'd0, 4'd15, 3'd0, 4'd9}) begin
         tests_failed++;
         $display("FAIL prev_wrap got=%h exp=%h", {status_a, song_a, status_b, song_b},
                  {3'd0, 4'd15, 3'd0, 4'd9});
      end
      start_play();
      pulse(0, 1, 0, 0);
      tests_run++;
      if ({status_a, song_a, status_b, song_b} !== {3'd1, 4'd0, 3'd1, 4'd0}) begin
         tests_failed++;
         $display("FAIL next_wrap got=%h exp=%h", {status_a, song_a, status_b, song_b},
                  {3'd1, 4'd0, 3'd1, 4'd0});
      end
   endtask

   task automatic test_pause();
      logic [8:0] obs;
      do_reset();
      repeat (2) pulse(0, 1, 0, 0);
      start_play();
      pulse(1, 0, 0, 0);
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== {3'd3, 4'd2, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL pause got=%h exp=%h", obs, {3'd3, 4'd2, 1'b0, 1'b0});
      end
      pulse(0, 0, 0, 1);
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== {3'd3, 4'd2, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL pause_ignores_done got=%h exp=%h", obs, {3'd3, 4'd2, 1'b0, 1'b0});
      end
      pulse(1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         obs = {status_a, song_a, play_a, rp_a};
         tests_run++;
         if (obs !== {3'd2, 4'd2, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL resume%0d got=%h exp=%h", i, obs, {3'd2, 4'd2, 1'b1, 1'b0});
         end
         tick();
      end
   endtask

   task automatic test_priority_reset();
      logic [8:0] obs;
      do_reset();
      repeat (5) pulse(0, 1, 0, 0);
      start_play();
      pulse(0, 1, 0, 1);
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== {3'd1, 4'd6, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL next_beats_done got=%h exp=%h", obs, {3'd1, 4'd6, 1'b0, 1'b1});
      end
      tick();
      pulse(0, 0, 0, 1);
      tick();
      tests_run++;
      if (status_a !== 3'd4) begin
         tests_failed++;
         $display("FAIL enter_gap got=%0d exp=4", status_a);
      end
      #2 rst = 1;
      #1;
      obs = {status_a, song_a, play_a, rp_a};
      tests_run++;
      if (obs !== 9'h000) begin
         tests_failed++;
         $display("FAIL async_reset got=%h exp=%h", obs, 9'h000);
      end
      tick();
      rst = 0;
   endtask

   task automatic test_random();
      logic [8:0] obs_a, exp_a, obs_b, exp_b;
      int r;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 19) == 0) repeat_mode = ~repeat_mode;
         if ($urandom_range(0, 599) == 0) begin
            rst = 1;
            tick();
            rst = 0;
         end else begin
            pulse(r == 2, r == 0, r == 1,
                  r == 3 && ma.state != M_GAP && mb.state != M_GAP);
         end
         obs_a = {status_a, song_a, play_a, rp_a};
         exp_a = {ma.state[2:0], ma.song[3:0], 1'(ma.state == M_PLAY), 1'(ma.state == M_LOAD)};
         obs_b = {status_b, song_b, play_b, rp_b};
         exp_b = {mb.state[2:0], mb.song[3:0], 1'(mb.state == M_PLAY), 1'(mb.state == M_LOAD)};
         tests_run++;
         if (obs_a !== exp_a) begin
            tests_failed++;
            $display("FAIL random16 cyc=%0d got=%h exp=%h", cyc, obs_a, exp_a);
         end
         tests_run++;
         if (obs_b !== exp_b) begin
            tests_failed++;
            $display("FAIL random10 cyc=%0d got=%h exp=%h", cyc, obs_b, exp_b);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst = 1;
      play_pause = 0; next_btn = 0; prev_btn = 0; song_done = 0; repeat_mode = 0;
      test_reset();
      test_gap_advance();
      test_last_song();
      test_wrap();
      test_pause();
      test_priority_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
